// File: rtl/pipe_hazard_pkg.sv
// Shared definitions for the pipeline hazard controller.
package pipe_hazard_pkg;

  // Mult/div sequencer states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } md_state_e;

  // Default EX-stall lengths for mult/multu and div/divu
  localparam int unsigned MUL_CYCLES_DEF = 4;
  localparam int unsigned DIV_CYCLES_DEF = 32;

  // Register $0 is hardwired to zero and never creates a dependency
  localparam int unsigned REG_ZERO = 0;

endpackage

// File: rtl/md_stall_counter.sv
// Mult/div stall sequencer: stalls for N cycles total, then pulses md_done.
module md_stall_counter
  import pipe_hazard_pkg::*;
#(
  parameter int unsigned MUL_CYCLES = MUL_CYCLES_DEF,
  parameter int unsigned DIV_CYCLES = DIV_CYCLES_DEF,
  parameter int unsigned CNT_W      = 6
) (
  input  logic clk,
  input  logic rst_n,
  input  logic md_start_e,
  input  logic md_is_div_e,
  output logic md_stall,
  output logic md_busy,
  output logic md_done
);

  md_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Next-state, counter and stall/done decode
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    md_stall = 1'b0;
    md_done  = 1'b0;
    case (state_q)
      IDLE: begin
        if (md_start_e) begin
          // The start cycle is itself the first stall cycle, so BUSY covers N-1
          md_stall = 1'b1;
          cnt_d    = md_is_div_e ? CNT_W'(DIV_CYCLES - 1) : CNT_W'(MUL_CYCLES - 1);
          state_d  = BUSY;
        end
      end
      BUSY: begin
        md_stall = 1'b1;
        cnt_d    = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        // Same mult/div still sits in E here, so md_start_e is ignored
        md_done = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
    md_busy = md_stall;
  end

  // State and counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central hazard controller: mult/div stall > branch flush > load-use interlock.
module pipe_hazard_ctrl
  import pipe_hazard_pkg::*;
#(
  parameter int unsigned REG_W      = 5,
  parameter int unsigned MUL_CYCLES = MUL_CYCLES_DEF,
  parameter int unsigned DIV_CYCLES = DIV_CYCLES_DEF,
  parameter int unsigned CNT_W      = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [REG_W-1:0] rs_d,
  input  logic [REG_W-1:0] rt_d,
  input  logic             memread_e,
  input  logic [REG_W-1:0] rt_e,
  input  logic             branch_taken_e,
  input  logic             md_start_e,
  input  logic             md_is_div_e,
  output logic             hold_f,
  output logic             hold_d,
  output logic             clear_d,
  output logic             hold_e,
  output logic             clear_e,
  output logic             clear_m,
  output logic             md_busy,
  output logic             md_done
);

  logic md_stall;
  logic md_busy_int;
  logic md_done_int;
  logic load_use;

  md_stall_counter #(
    .MUL_CYCLES (MUL_CYCLES),
    .DIV_CYCLES (DIV_CYCLES),
    .CNT_W      (CNT_W)
  ) u_md (
    .clk         (clk),
    .rst_n       (rst_n),
    .md_start_e  (md_start_e),
    .md_is_div_e (md_is_div_e),
    .md_stall    (md_stall),
    .md_busy     (md_busy_int),
    .md_done     (md_done_int)
  );

  // Load-use dependency between the load in E and the sources in D
  always_comb begin
    load_use = memread_e && (rt_e != REG_W'(REG_ZERO)) &&
               ((rt_e == rs_d) || (rt_e == rt_d));
  end

  // Priority mux driving the pipeline register controls
  always_comb begin
    hold_f  = 1'b0;
    hold_d  = 1'b0;
    clear_d = 1'b0;
    hold_e  = 1'b0;
    clear_e = 1'b0;
    clear_m = 1'b0;
    md_busy = 1'b0;
    md_done = 1'b0;
    if (!rst_n) begin
      // The FSM sits in IDLE during reset but still decodes md_start_e,
      // so busy is gated here rather than relying on the sub-module
      clear_d = 1'b1;
      clear_e = 1'b1;
      clear_m = 1'b1;
    end else if (md_stall) begin
      hold_f  = 1'b1;
      hold_d  = 1'b1;
      hold_e  = 1'b1;
      clear_m = 1'b1;
      md_busy = md_busy_int;
    end else begin
      md_done = md_done_int;
      if (branch_taken_e) begin
        clear_d = 1'b1;
        clear_e = 1'b1;
      end else if (load_use) begin
        hold_f  = 1'b1;
        hold_d  = 1'b1;
        clear_e = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl with a cycle-count reference model.
module tb_pipe_hazard_ctrl;

  localparam int REG_W = 5;
  localparam int MULN  = 4;
  localparam int DIVN  = 32;

  // Output vector order: {hold_f,hold_d,clear_d,hold_e,clear_e,clear_m,md_busy,md_done}
  localparam logic [7:0] V_RESET = 8'b0010_1100;
  localparam logic [7:0] V_STALL = 8'b1101_0110;
  localparam logic [7:0] V_FLUSH = 8'b0010_1000;
  localparam logic [7:0] V_LU    = 8'b1100_1000;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [REG_W-1:0] rs_d, rt_d, rt_e;
  logic             memread_e, branch_taken_e, md_start_e, md_is_div_e;
  logic             hold_f, hold_d, clear_d, hold_e, clear_e, clear_m, md_busy, md_done;
  logic [7:0]       obs, exp_v;

  int checks = 0;
  int errors = 0;

  // Reference model: remaining stall cycles and a pending done pulse
  int m_rem  = 0;
  bit m_done = 1'b0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(
    .REG_W      (REG_W),
    .MUL_CYCLES (MULN),
    .DIV_CYCLES (DIVN),
    .CNT_W      (6)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .rs_d           (rs_d),
    .rt_d           (rt_d),
    .memread_e      (memread_e),
    .rt_e           (rt_e),
    .branch_taken_e (branch_taken_e),
    .md_start_e     (md_start_e),
    .md_is_div_e    (md_is_div_e),
    .hold_f         (hold_f),
    .hold_d         (hold_d),
    .clear_d        (clear_d),
    .hold_e         (hold_e),
    .clear_e        (clear_e),
    .clear_m        (clear_m),
    .md_busy        (md_busy),
    .md_done        (md_done)
  );

  assign obs = {hold_f, hold_d, clear_d, hold_e, clear_e, clear_m, md_busy, md_done};

  function automatic logic [7:0] model_exp();
    bit lu;
    lu = memread_e && (rt_e != 0) && (rt_e == rs_d || rt_e == rt_d);
    if (!rst_n) return V_RESET;
    if (m_rem > 0 || (!m_done && md_start_e)) return V_STALL;
    if (branch_taken_e) return V_FLUSH | {7'b0, m_done};
    if (lu) return V_LU | {7'b0, m_done};
    return {7'b0, m_done};
  endfunction

  task automatic model_advance();
    if (!rst_n) begin
      m_rem  = 0;
      m_done = 1'b0;
    end else if (m_rem > 0) begin
      m_rem = m_rem - 1;
      if (m_rem == 0) m_done = 1'b1;
    end else if (m_done) begin
      m_done = 1'b0;
    end else if (md_start_e) begin
      m_rem = (md_is_div_e ? DIVN : MULN) - 1;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_advance();
    #1;
  endtask

  task automatic assert_reset();
    rst_n  = 1'b0;
    m_rem  = 0;
    m_done = 1'b0;
  endtask

  task automatic set_in(input bit mr, input int rte, input int rsd, input int rtd,
                        input bit br, input bit st, input bit dv);
    memread_e      = mr;
    rt_e           = REG_W'(rte);
    rs_d           = REG_W'(rsd);
    rt_d           = REG_W'(rtd);
    branch_taken_e = br;
    md_start_e     = st;
    md_is_div_e    = dv;
  endtask

  task automatic test_reset();
    assert_reset();
    set_in(0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    checks++;
    if (obs !== V_RESET) begin
      errors++;
      $display("FAIL reset_idle got %b exp %b", obs, V_RESET);
    end
    // Active requests must not leak through while reset is held
    set_in(1, 3, 3, 0, 1, 1, 1);
    #1;
    checks++;
    if (obs !== V_RESET) begin
      errors++;
      $display("FAIL reset_forced got %b exp %b", obs, V_RESET);
    end
    tick();
    rst_n = 1'b1;
    set_in(0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    checks++;
    if (obs !== 8'b0) begin
      errors++;
      $display("FAIL reset_release got %b exp %b", obs, 8'b0);
    end
    // Mid-run: start a mult then pull reset while stalled
    tick();
    set_in(0, 0, 0, 0, 0, 1, 0);
    tick();
    tick();
    assert_reset();
    #1;
    checks++;
    if (obs !== V_RESET) begin
      errors++;
      $display("FAIL reset_midrun got %b exp %b", obs, V_RESET);
    end
    tick();
    rst_n = 1'b1;
    set_in(0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    checks++;
    if (obs !== 8'b0) begin
      errors++;
      $display("FAIL reset_midrun_release got %b exp %b", obs, 8'b0);
    end
    tick();
  endtask

  task automatic test_load_use();
    set_in(1, 5, 5, 7, 0, 0, 0);
    @(negedge clk);
    checks++;
    if (obs !== V_LU) begin
      errors++;
      $display("FAIL lu_rs got %b exp %b", obs, V_LU);
    end
    tick();
    set_in(1, 9, 2, 9, 0, 0, 0);
    @(negedge clk);
    checks++;
    if (obs !== V_LU) begin
      errors++;
      $display("FAIL lu_rt got %b exp %b", obs, V_LU);
    end
    tick();
    set_in(1, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    checks++;
    if (obs !== 8'b0) begin
      errors++;
      $display("FAIL lu_reg0 got %b exp %b", obs, 8'b0);
    end
    tick();
    set_in(0, 5, 5, 5, 0, 0, 0);
    @(negedge clk);
    checks++;
    if (obs !== 8'b0) begin
      errors++;
      $display("FAIL lu_noload got %b exp %b", obs, 8'b0);
    end
    tick();
    set_in(1, 6, 5, 7, 0, 0, 0);
    @(negedge clk);
    checks++;
    if (obs !== 8'b0) begin
      errors++;
      $display("FAIL lu_nomatch got %b exp %b", obs, 8'b0);
    end
    tick();
  endtask

  task automatic test_flush();
    set_in(1, 5, 5, 0, 1, 0, 0);
    @(negedge clk);
    checks++;
    if (obs !== V_FLUSH || hold_f !== 1'b0) begin
      errors++;
      $display("FAIL flush_over_lu got %b exp %b", obs, V_FLUSH);
    end
    tick();
    set_in(0, 0, 0, 0, 0, 0, 0);
    tick();
  endtask

  task automatic test_mult();
    int stalls = 0;
    set_in(0, 0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      exp_v = model_exp();
      checks++;
      if (obs !== exp_v || hold_e !== (i < MULN) || md_done !== (i == MULN)) begin
        errors++;
        $display("FAIL mult_cyc%0d got %b exp %b", i, obs, exp_v);
      end
      if (hold_e) stalls++;
      tick();
    end
    set_in(0, 0, 0, 0, 0, 0, 0);
    checks++;
    if (stalls != MULN) begin
      errors++;
      $display("FAIL mult_len got %0d exp %0d", stalls, MULN);
    end
    tick();
  endtask

  task automatic test_div_masked();
    set_in(0, 0, 0, 0, 0, 1, 1);
    for (int i = 0; i <= DIVN; i++) begin
      if (i == 10) set_in(1, 4, 4, 0, 1, 1, 1);
      else if (i == 11) set_in(0, 0, 0, 0, 0, 1, 1);
      #1;
      @(negedge clk);
      exp_v = model_exp();
      checks++;
      if (obs !== exp_v || hold_e !== (i < DIVN) || md_done !== (i == DIVN) ||
          (i < DIVN && (clear_d !== 1'b0 || clear_e !== 1'b0))) begin
        errors++;
        $display("FAIL div_cyc%0d got %b exp %b", i, obs, exp_v);
      end
      tick();
    end
    set_in(0, 0, 0, 0, 0, 0, 0);
    tick();
  endtask

  task automatic test_reset_mid_div();
    set_in(0, 0, 0, 0, 0, 1, 1);
    for (int i = 0; i < 12; i++) tick();
    assert_reset();
    #1;
    checks++;
    if (md_busy !== 1'b0 || md_done !== 1'b0 || obs !== V_RESET) begin
      errors++;
      $display("FAIL rst_div_abort got %b exp %b", obs, V_RESET);
    end
    tick();
    rst_n = 1'b1;
    set_in(0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      checks++;
      if (md_done !== 1'b0 || obs !== model_exp()) begin
        errors++;
        $display("FAIL rst_div_after%0d got %b exp %b", i, obs, model_exp());
      end
      tick();
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(99) == 0) assert_reset();
      else rst_n = 1'b1;
      set_in(($urandom_range(1) == 1), $urandom_range(3), $urandom_range(3), $urandom_range(3),
             ($urandom_range(3) == 0), ($urandom_range(7) == 0), ($urandom_range(3) == 0));
      @(negedge clk);
      exp_v = model_exp();
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL rand_%0d got %b exp %b", i, obs, exp_v);
      end
      tick();
    end
    rst_n = 1'b1;
    set_in(0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_load_use();
    test_flush();
    test_mult();
    test_div_masked();
    test_reset_mid_div();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
